seq_det_sched: RTL
==================

# seq_det_sched

Round-robin scheduler that shares one "101" Moore sequence-detector core among 2**CHW independent serial bit channels. Each channel's 2-bit detector state is saved in a per-channel register file; the scheduler grants at most one channel per cycle, applies that channel's bit to the shared next-state logic and writes the state back. It sits between the serial front-end lanes and the event-collection logic, replacing one detector instance per lane.

## Interface

- CHW, 2: channel-index width; channel count CH = 2**CHW.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  CH  per-channel bit-available flag.
- in_bit  in  CH  per-channel serial bit, sampled when accepted.
- in_ready  out  CH  one-hot grant, combinational; at most one bit set; a bit is consumed when in_valid[i] & in_ready[i].
- ch_clr  in  CH  per-channel synchronous clear of detector state (and counter, if present).
- match_valid  out  1  registered one-cycle pulse: a channel has just detected "101".
- match_ch  out  CHW  registered index of the matching channel; valid only with match_valid.
- match_cnt  out  8*CH  per-channel match counters, channel i at [8i+7:8i]; present only with SEQ_SCHED_CNT_EN.

## Operation

- Per-channel state encoding: A=00 (idle), B=01 (seen 1), C=10 (seen 10), D=11 (seen 101).
- Transitions on an accepted bit x: A: x→B, !x→A; B: x→B, !x→C; C: x→D, !x→A; D: x→B, !x→C.
- Overlapping detection: stream 1,0,1,0,1 produces two matches.
- Match: asserted when the written-back state is D.
- Arbitration: rotating pointer ptr (CHW bits). Eligible channel = in_valid[i] & !ch_clr[i]. Grant the first eligible channel scanning ptr, ptr+1, ... modulo CH. On a grant to channel g, ptr ← g+1 mod CH. With no grant, ptr holds.
- ch_clr[i] forces state[i] ← A on the next edge and masks in_ready[i] that cycle; the bit is not consumed. Clears on other channels do not affect the grant.
- Non-granted channels hold their state; no bits are dropped; in_valid may stay high across cycles.
- Reset: all states A, ptr 0, match_valid 0, match_ch 0, counters 0. in_ready follows in_valid combinationally, so the first grant is possible in the first cycle after rst deasserts.

## Timing

- Accept in cycle t → state[g] updated at the end of cycle t → match_valid/match_ch high in cycle t+1 for exactly one cycle. Latency 1.
- Throughput: one bit per cycle in aggregate; each channel gets at least one grant every CH cycles while requesting.
- Back-to-back matches on different channels give consecutive match_valid pulses with differing match_ch.
- rst asserted mid-stream: all outputs return to reset values immediately, without waiting for a clock edge; partial sequences are lost.
- ch_clr[g] and acceptance on g cannot coincide because of the masking. ch_clr on the channel that matched in cycle t does not cancel the t+1 pulse.

## Configuration

- SEQ_SCHED_CNT_EN defined: the match_cnt port and CH 8-bit counters are present. Counter i increments on each match of channel i, saturates at 255, and is zeroed by ch_clr[i] or rst. When clear and increment occur together, the clear wins.
- SEQ_SCHED_CNT_EN undefined: no counters, no match_cnt port; all other behaviour is identical.

## Test plan

- Reset/single lane: CHW=2, only ch0 valid, bits 1,0,1 → in_ready=0001 each cycle; match_valid=1, match_ch=0 one cycle after the third accept; state of ch0 is D.
- Overlap: ch2 alone, bits 1,0,1,0,1 → exactly two match pulses, match_ch=2, two cycles apart.
- Fairness: all four in_valid held high → in_ready sequence 0001,0010,0100,1000,0001; interleaved "101" streams on every channel → matches from channels 0,1,2,3 in order on consecutive cycles.
- Clear: ch1 reaches C (bits 1,0), then ch_clr[1]=1 while in_valid[1]=1 → in_ready[1]=0 that cycle. A next bit 1 → state B and no match.
- Async reset mid-stream: assert rst between clock edges with ch3 in C → match_valid, ptr and all states are 0 immediately. A following bit 1 on ch3 gives no match.
- Counter (SEQ_SCHED_CNT_EN): 300 matches on ch0 → match_cnt[7:0]=255. Then ch_clr[0] → 0 on the next cycle, and other channels' counts are unchanged.

Source files
------------

// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin scheduler sharing one "101" Moore detector core
// among CH = 2**CHW serial bit channels. Per-channel detector state lives in
// a small register file; one channel is granted per cycle.
//
// Optional feature macro: SEQ_SCHED_CNT_EN adds per-channel 8-bit saturating
// match counters and the match_cnt port.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     [CH]   per-channel bit-available flag
//   in_bit       [CH]   per-channel serial bit
//   in_ready     [CH]   combinational one-hot grant (consume = valid & ready)
//   ch_clr       [CH]   per-channel synchronous clear (state and counter)
//   match_valid         registered one-cycle "101" detect pulse
//   match_ch     [CHW]  registered index of the matching channel
//   match_cnt    [8*CH] per-channel match counters (SEQ_SCHED_CNT_EN only)
module seq_det_sched #(
  parameter int unsigned CHW = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [(2**CHW)-1:0]   in_valid,
  input  logic [(2**CHW)-1:0]   in_bit,
  output logic [(2**CHW)-1:0]   in_ready,
  input  logic [(2**CHW)-1:0]   ch_clr,
  output logic                  match_valid,
  output logic [CHW-1:0]        match_ch
`ifdef SEQ_SCHED_CNT_EN
  ,
  output logic [8*(2**CHW)-1:0] match_cnt
`endif
);

  localparam int unsigned CH    = 2**CHW;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_A = 2'b00,  // idle
    ST_B = 2'b01,  // seen 1
    ST_C = 2'b10,  // seen 10
    ST_D = 2'b11   // seen 101
  } state_e;

  state_e         state_q [CH];
  state_e         state_d [CH];
  logic [CHW-1:0] ptr_q, ptr_d;
  logic           match_valid_q, match_valid_d;
  logic [CHW-1:0] match_ch_q, match_ch_d;

  logic [CH-1:0]  eligible;
  logic           grant_vld;
  logic [CHW-1:0] grant_idx;
  logic [CHW-1:0] scan_idx;
  state_e         grant_next;

  // Shared detector next-state function
  function automatic state_e det_next(input state_e s, input logic x);
    state_e n;
    case (s)
      ST_A:    n = x ? ST_B : ST_A;
      ST_B:    n = x ? ST_B : ST_C;
      ST_C:    n = x ? ST_D : ST_A;
      default: n = x ? ST_B : ST_C;
    endcase
    return n;
  endfunction

  // A channel being cleared is not eligible this cycle
  assign eligible = in_valid & ~ch_clr;

  // Rotating-priority scan starting at ptr; index arithmetic wraps mod CH
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      scan_idx = ptr_q + CHW'(k);
      if (!grant_vld && eligible[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // One-hot grant
  always_comb begin
    in_ready = '0;
    if (grant_vld) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  assign grant_next = det_next(state_q[grant_idx], in_bit[grant_idx]);

  // Next-state for register file, pointer and match outputs
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      if (ch_clr[i]) begin
        state_d[i] = ST_A;
      end
    end
    ptr_d         = ptr_q;
    match_valid_d = 1'b0;
    match_ch_d    = match_ch_q;
    if (grant_vld) begin
      // granted channel is never cleared in the same cycle (masked above)
      state_d[grant_idx] = grant_next;
      ptr_d              = grant_idx + CHW'(1);
      if (grant_next == ST_D) begin
        match_valid_d = 1'b1;
        match_ch_d    = grant_idx;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        state_q[i] <= ST_A;
      end
      ptr_q         <= '0;
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
      end
      ptr_q         <= ptr_d;
      match_valid_q <= match_valid_d;
      match_ch_q    <= match_ch_d;
    end
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;

`ifdef SEQ_SCHED_CNT_EN
  logic [CNT_W-1:0] cnt_q [CH];
  logic [CNT_W-1:0] cnt_d [CH];

  // Saturating counters; clear has priority over increment
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (match_valid_d && (grant_idx == CHW'(i)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      if (ch_clr[i]) begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_cnt_out
    assign match_cnt[CNT_W*gi +: CNT_W] = cnt_q[gi];
  end
`endif

endmodule
